// File: rtl/vga_sched_pkg.sv
// Shared definitions for the VGA framebuffer write scheduler.
package vga_sched_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_WAIT_CLR = 2'd1,
      ST_CLEAR    = 2'd2
   } sched_state_e;

   localparam int SCHED_ADDR_W     = 19;
   localparam int SCHED_DATA_W     = 8;
   localparam int SCHED_FIFO_DEPTH = 8;
   localparam int SCHED_FB_PIXELS  = 307200;

   // Pointer width for a power-of-two FIFO: one extra bit separates full from empty.
   function automatic int ptr_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/vga_write_scheduler_if.sv
// Processor-side, clear-control and framebuffer-side signals of the scheduler.
interface vga_write_scheduler_if
   import vga_sched_pkg::*;
#(
   parameter int ADDR_W = SCHED_ADDR_W,
   parameter int DATA_W = SCHED_DATA_W
);

   logic              cpu_wren;
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_data;
   logic              cpu_stall;
   logic              clear_req;
   logic [DATA_W-1:0] clear_color;
   logic              clear_busy;
   logic              fb_ready;
   logic              vga_wren_enable;
   logic [ADDR_W-1:0] vga_data_addr;
   logic [DATA_W-1:0] vga_data_write;

   modport master (
      output cpu_wren, cpu_addr, cpu_data, clear_req, clear_color, fb_ready,
      input  cpu_stall, clear_busy, vga_wren_enable, vga_data_addr, vga_data_write
   );

   modport slave (
      input  cpu_wren, cpu_addr, cpu_data, clear_req, clear_color, fb_ready,
      output cpu_stall, clear_busy, vga_wren_enable, vga_data_addr, vga_data_write
   );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers for full/empty detection.
module sync_fifo
   import vga_sched_pkg::*;
#(
   parameter int WIDTH = SCHED_ADDR_W + SCHED_DATA_W,
   parameter int DEPTH = SCHED_FIFO_DEPTH
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty
);

   localparam int PTR_W = ptr_width(DEPTH);
   localparam int IDX_W = PTR_W - 1;

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             do_push;
   logic             do_pop;

   assign empty    = (wr_ptr_q == rd_ptr_q);
   assign full     = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
                     (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]);
   assign do_push  = push && !full;
   assign do_pop   = pop && !empty;
   assign pop_data = mem_q[rd_ptr_q[IDX_W-1:0]];

   // Pointer advance on accepted push/pop.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
   end

   // Pointer registers; a reset discards everything buffered.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage array; contents are don't-care until written, so no reset.
   always_ff @(posedge clock) begin
      if (do_push) mem_q[wr_ptr_q[IDX_W-1:0]] <= push_data;
   end

endmodule

// File: rtl/vga_write_scheduler.sv
// Owns the framebuffer write port: drains buffered CPU pixel writes and
// runs the full-screen clear sweep, stalling the CPU when it cannot accept.
//
//   state       | meaning
//   ------------+-----------------------------------------------------
//   ST_IDLE     | draining CPU write FIFO, clear requests accepted
//   ST_WAIT_CLR | clear pending; CPU stalled until the FIFO drains
//   ST_CLEAR    | sweeping pixels 0..FB_PIXELS-1 with the stored colour
module vga_write_scheduler
   import vga_sched_pkg::*;
#(
   parameter int FIFO_DEPTH = SCHED_FIFO_DEPTH,
   parameter int ADDR_W     = SCHED_ADDR_W,
   parameter int DATA_W     = SCHED_DATA_W,
   parameter int FB_PIXELS  = SCHED_FB_PIXELS
) (
   input  logic                  clock,
   input  logic                  reset,
   vga_write_scheduler_if.slave  bus
);

   localparam int                ENTRY_W  = ADDR_W + DATA_W;
   localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(FB_PIXELS - 1);

   sched_state_e      state_q, state_d;
   logic [ADDR_W-1:0] count_q, count_d;
   logic [DATA_W-1:0] color_q, color_d;
   logic              wren_q,  wren_d;
   logic [ADDR_W-1:0] addr_q,  addr_d;
   logic [DATA_W-1:0] data_q,  data_d;

   logic               fifo_push;
   logic               fifo_pop;
   logic               fifo_full;
   logic               fifo_empty;
   logic [ENTRY_W-1:0] fifo_rdata;

   sync_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clock     (clock),
      .reset     (reset),
      .push      (fifo_push),
      .push_data ({bus.cpu_addr, bus.cpu_data}),
      .pop       (fifo_pop),
      .pop_data  (fifo_rdata),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   // Stall while full, and while a clear waits for older writes to drain.
   assign bus.cpu_stall       = fifo_full || (state_q == ST_WAIT_CLR);
   assign fifo_push           = bus.cpu_wren && !bus.cpu_stall;
   assign bus.clear_busy      = (state_q != ST_IDLE);
   assign bus.vga_wren_enable = wren_q;
   assign bus.vga_data_addr   = addr_q;
   assign bus.vga_data_write  = data_q;

   // Next-state, clear counter and framebuffer output selection.
   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      color_d  = color_q;
      wren_d   = 1'b0;
      addr_d   = addr_q;
      data_d   = data_q;
      fifo_pop = 1'b0;

      case (state_q)
         ST_IDLE: begin
            fifo_pop = !fifo_empty && bus.fb_ready;
            if (bus.clear_req) begin
               color_d = bus.clear_color;
               state_d = ST_WAIT_CLR;
            end
         end
         ST_WAIT_CLR: begin
            fifo_pop = !fifo_empty && bus.fb_ready;
            if (fifo_empty) begin
               state_d = ST_CLEAR;
               count_d = '0;
            end
         end
         ST_CLEAR: begin
            // CPU writes queued meanwhile stay put so they land on top of the fill.
            if (bus.fb_ready) begin
               wren_d = 1'b1;
               addr_d = count_q;
               data_d = color_q;
               if (count_q == LAST_PIX) begin
                  state_d = ST_IDLE;
                  count_d = '0;
               end else begin
                  count_d = count_q + 1'b1;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
            count_d = '0;
         end
      endcase

      if (fifo_pop) begin
         wren_d           = 1'b1;
         {addr_d, data_d} = fifo_rdata;
      end
   end

   // State, counter, colour and registered framebuffer port.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         count_q <= '0;
         color_q <= '0;
         wren_q  <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         color_q <= color_d;
         wren_q  <= wren_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
      end
   end

endmodule

// File: tb/tb_vga_write_scheduler.sv
// Scoreboard bench for vga_write_scheduler with a 16-pixel framebuffer.
module tb_vga_write_scheduler;

   localparam int ADDR_W = 19;
   localparam int DATA_W = 8;
   localparam int DEPTH  = 8;
   localparam int FBP    = 16;

   typedef struct {
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] d;
   } exp_t;

   logic clock = 1'b0;
   logic reset = 1'b1;
   int   n_vec = 0;
   int   n_err = 0;
   int   strobe_cnt = 0;
   exp_t exp_q[$];

   vga_write_scheduler_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus_if ();

   vga_write_scheduler #(
      .FIFO_DEPTH (DEPTH),
      .ADDR_W     (ADDR_W),
      .DATA_W     (DATA_W),
      .FB_PIXELS  (FBP)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus_if)
   );

   always #5 clock = ~clock;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Scoreboard: every strobe must match the oldest expected write.
   always @(negedge clock) begin
      if (!reset && bus_if.vga_wren_enable) begin
         strobe_cnt++;
         if (exp_q.size() == 0) begin
            check_val("extra_strobe_addr", 32'(bus_if.vga_data_addr), 32'hFFFF_FFFF);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check_val("sb_addr", 32'(bus_if.vga_data_addr), 32'(e.a));
            check_val("sb_data", 32'(bus_if.vga_data_write), 32'(e.d));
         end
      end
   end

   task automatic cpu_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      bit done;
      exp_t e;
      done = 1'b0;
      bus_if.cpu_wren = 1'b1;
      bus_if.cpu_addr = a;
      bus_if.cpu_data = d;
      for (int i = 0; i < 400 && !done; i++) begin
         if (!bus_if.cpu_stall) begin
            done = 1'b1;
            e.a = a;
            e.d = d;
            exp_q.push_back(e);
         end
         @(negedge clock);
      end
      bus_if.cpu_wren = 1'b0;
      if (!done) check_val("write_timeout", 32'(done), 32'd1);
   endtask

   task automatic do_clear(input logic [DATA_W-1:0] c);
      exp_t e;
      bus_if.clear_req   = 1'b1;
      bus_if.clear_color = c;
      for (int i = 0; i < FBP; i++) begin
         e.a = ADDR_W'(i);
         e.d = c;
         exp_q.push_back(e);
      end
      @(negedge clock);
      bus_if.clear_req = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int i;
      for (i = 0; i < 400 && bus_if.clear_busy; i++) @(negedge clock);
      check_val({tag, "_busy_timeout"}, 32'(bus_if.clear_busy), 32'd0);
      check_val({tag, "_last_fill_addr"}, 32'(bus_if.vga_data_addr), 32'(FBP - 1));
      check_val({tag, "_last_fill_wren"}, 32'(bus_if.vga_wren_enable), 32'd1);
   endtask

   task automatic wait_drain(input string tag);
      for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(negedge clock);
      @(negedge clock);
      check_val({tag, "_sb_left"}, 32'(exp_q.size()), 32'd0);
   endtask

   task automatic single_write(input string tag, input logic [ADDR_W-1:0] a,
                               input logic [DATA_W-1:0] d);
      bus_if.fb_ready = 1'b1;
      check_val({tag, "_stall_before"}, 32'(bus_if.cpu_stall), 32'd0);
      cpu_write(a, d);
      check_val({tag, "_wren_n"}, 32'(bus_if.vga_wren_enable), 32'd0);
      @(negedge clock);
      check_val({tag, "_wren_n1"}, 32'(bus_if.vga_wren_enable), 32'd1);
      check_val({tag, "_stall_n1"}, 32'(bus_if.cpu_stall), 32'd0);
      @(negedge clock);
      check_val({tag, "_wren_n2"}, 32'(bus_if.vga_wren_enable), 32'd0);
      wait_drain(tag);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired with %0d expected writes outstanding", exp_q.size());
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      bus_if.cpu_wren    = 1'b0;
      bus_if.cpu_addr    = '0;
      bus_if.cpu_data    = '0;
      bus_if.clear_req   = 1'b0;
      bus_if.clear_color = '0;
      bus_if.fb_ready    = 1'b0;
      repeat (3) @(negedge clock);
      check_val("rst_wren", 32'(bus_if.vga_wren_enable), 32'd0);
      check_val("rst_addr", 32'(bus_if.vga_data_addr), 32'd0);
      check_val("rst_data", 32'(bus_if.vga_data_write), 32'd0);
      check_val("rst_busy", 32'(bus_if.clear_busy), 32'd0);
      check_val("rst_stall", 32'(bus_if.cpu_stall), 32'd0);
      reset = 1'b0;
      @(negedge clock);

      // 1: single write latency
      single_write("s1", 19'h00123, 8'hA5);

      // 2: back-pressure with 9 writes
      bus_if.fb_ready = 1'b0;
      for (int i = 0; i < DEPTH; i++) cpu_write(ADDR_W'(i), DATA_W'(8'h10 + i));
      check_val("s2_stall_full", 32'(bus_if.cpu_stall), 32'd1);
      bus_if.cpu_wren = 1'b1;
      bus_if.cpu_addr = ADDR_W'(8);
      bus_if.cpu_data = 8'h18;
      repeat (2) @(negedge clock);
      check_val("s2_stall_held", 32'(bus_if.cpu_stall), 32'd1);
      check_val("s2_no_drain", 32'(strobe_cnt - 1), 32'd0);
      bus_if.fb_ready = 1'b1;
      cpu_write(ADDR_W'(8), 8'h18);
      wait_drain("s2");

      // 3: ordering around clear
      bus_if.fb_ready = 1'b0;
      for (int i = 0; i < 3; i++) cpu_write(ADDR_W'(19'h100 + i), DATA_W'(8'h50 + i));
      do_clear(8'h3C);
      check_val("s3_busy", 32'(bus_if.clear_busy), 32'd1);
      check_val("s3_stall_wait", 32'(bus_if.cpu_stall), 32'd1);
      @(negedge clock);
      bus_if.fb_ready = 1'b1;
      check_val("s3_stall_pre", 32'(bus_if.cpu_stall), 32'd1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         check_val("s3_stall_drain", 32'(bus_if.cpu_stall), 32'd1);
      end
      @(negedge clock);
      check_val("s3_stall_clear", 32'(bus_if.cpu_stall), 32'd0);
      wait_idle("s3");
      wait_drain("s3");

      // 4: CPU writes during clear land after the fill
      do_clear(8'h77);
      @(negedge clock);
      cpu_write(19'd5, 8'hFF);
      cpu_write(19'd6, 8'h00);
      check_val("s4_busy", 32'(bus_if.clear_busy), 32'd1);
      wait_idle("s4");
      wait_drain("s4");

      // 5: bubbles and an ignored second request
      base = strobe_cnt;
      do_clear(8'hC3);
      for (int i = 0; i < 400 && bus_if.clear_busy; i++) begin
         bus_if.fb_ready    = (i % 2 == 1);
         bus_if.clear_req   = (i == 6);
         bus_if.clear_color = 8'h11;
         @(negedge clock);
      end
      bus_if.clear_req = 1'b0;
      bus_if.fb_ready  = 1'b1;
      check_val("s5_busy_done", 32'(bus_if.clear_busy), 32'd0);
      repeat (25) @(negedge clock);
      check_val("s5_fill_count", 32'(strobe_cnt - base), 32'(FBP));
      check_val("s5_busy_after", 32'(bus_if.clear_busy), 32'd0);
      wait_drain("s5");

      // 6: reset mid-clear at counter 7
      do_clear(8'h99);
      begin
         bit hit;
         hit = 1'b0;
         for (int i = 0; i < 100 && !hit; i++) begin
            if (bus_if.vga_wren_enable && bus_if.vga_data_addr == 19'd6 && bus_if.clear_busy)
               hit = 1'b1;
            else
               @(negedge clock);
         end
         check_val("s6_reached_7", 32'(hit), 32'd1);
      end
      #2 reset = 1'b1;
      #1;
      check_val("s6_wren", 32'(bus_if.vga_wren_enable), 32'd0);
      check_val("s6_addr", 32'(bus_if.vga_data_addr), 32'd0);
      check_val("s6_data", 32'(bus_if.vga_data_write), 32'd0);
      check_val("s6_busy", 32'(bus_if.clear_busy), 32'd0);
      check_val("s6_stall", 32'(bus_if.cpu_stall), 32'd0);
      exp_q.delete();
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      single_write("s6w", 19'h00123, 8'hA5);
      repeat (5) @(negedge clock);
      check_val("end_sb_empty", 32'(exp_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
